// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
// Holds the FSM state enum, the RV32I major opcodes the sequencer decodes,
// the ALU operation codes, the ALU operation classes understood by
// alu_decoder, and the datapath mux-select encodings.
package ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_LUI,
        S_EXEC_AUIPC,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MRWAIT,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_EXEC_JALR,
        S_JUMP,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_t;

    // ADD/SUB force the operation; FUNCT derives it from funct3/funct7_5.
    typedef enum logic [1:0] {
        ALU_CLS_ADD   = 2'd0,
        ALU_CLS_SUB   = 2'd1,
        ALU_CLS_FUNCT = 2'd2
    } alu_class_t;

    typedef enum logic [1:0] {
        SRC_A_PC     = 2'd0,
        SRC_A_OLD_PC = 2'd1,
        SRC_A_RS1    = 2'd2,
        SRC_A_ZERO   = 2'd3
    } src_a_t;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } src_b_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'd0,
        RES_MEM_DATA   = 2'd1,
        RES_ALU_RESULT = 2'd2
    } result_src_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
// Ports:
//   alu_class  in  2  ALU_CLS_ADD / ALU_CLS_SUB / ALU_CLS_FUNCT
//   funct3     in  3  instruction[14:12]
//   funct7_5   in  1  instruction[30], already masked by the caller for I-type
//   alu_ctrl   out 4  ALU operation code
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_class)
            ALU_CLS_SUB: alu_ctrl = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct3)
                    3'b000:  alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle RV32I core. Walks each instruction
// through fetch / decode / execute / memory / writeback and drives every
// enable and mux select of the shared datapath, counts retired instructions
// and halts on SYSTEM or unknown opcodes.
// Parameters: MEM_LATENCY (1..4) read latency in cycles, CNT_WIDTH instret width.
// Ports:
//   clk, reset (async, active high)
//   opcode/funct3/funct7_5 : IR fields;  branch_cond : comparator result
//   pc_write_en, old_pc_write_en, ir_write_en, register_write_en,
//   memory_write_en, mem_read_en : datapath enables
//   adr_src, pc_src, alu_src_a, alu_src_b, alu_ctrl, result_src : mux selects
//   illegal, halted : sticky halt flags;  instret : retired-instruction count
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 branch_cond,
    output logic                 pc_write_en,
    output logic                 old_pc_write_en,
    output logic                 ir_write_en,
    output logic                 register_write_en,
    output logic                 memory_write_en,
    output logic                 mem_read_en,
    output logic                 adr_src,
    output logic                 pc_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_ctrl,
    output logic [1:0]           result_src,
    output logic                 illegal,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instret
);

    // Wait-state down-counter: loaded with MEM_LATENCY-1, last cycle at zero.
    localparam int                WAIT_W    = 2;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LATENCY - 1);

    state_t                state_q,   state_d;
    logic [WAIT_W-1:0]     wait_q,    wait_d;
    logic [CNT_WIDTH-1:0]  instret_q, instret_d;
    logic                  illegal_q, illegal_d;
    logic                  halted_q,  halted_d;

    alu_class_t            alu_class;
    logic                  funct7_eff;
    logic                  retire;

    alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .funct3    (funct3),
        .funct7_5  (funct7_eff),
        .alu_ctrl  (alu_ctrl)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned and infer a latch.
        state_d           = state_q;
        wait_d            = wait_q;
        instret_d         = instret_q;
        illegal_d         = illegal_q;
        halted_d          = halted_q;
        retire            = 1'b0;
        alu_class         = ALU_CLS_ADD;
        funct7_eff        = 1'b0;
        pc_write_en       = 1'b0;
        old_pc_write_en   = 1'b0;
        ir_write_en       = 1'b0;
        register_write_en = 1'b0;
        memory_write_en   = 1'b0;
        mem_read_en       = 1'b0;
        adr_src           = 1'b0;
        pc_src            = 1'b0;
        alu_src_a         = SRC_A_PC;
        alu_src_b         = SRC_B_RS2;
        result_src        = RES_ALU_OUT;

        case (state_q)
            S_FETCH: begin
                mem_read_en = 1'b1;
                wait_d      = WAIT_INIT;
                state_d     = S_FWAIT;
            end
            S_FWAIT: begin
                if (wait_q == '0) begin
                    // Data is valid now: capture IR, remember this PC, advance PC by 4.
                    ir_write_en     = 1'b1;
                    old_pc_write_en = 1'b1;
                    pc_write_en     = 1'b1;
                    alu_src_b       = SRC_B_FOUR;
                    state_d         = S_DECODE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_DECODE: begin
                // Precompute old_pc + imm so branch/JAL targets sit in alu_out.
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JUMP;
                    OP_JALR:            state_d = S_EXEC_JALR;
                    OP_LUI:             state_d = S_EXEC_LUI;
                    OP_AUIPC:           state_d = S_EXEC_AUIPC;
                    OP_FENCE: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_SYSTEM: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        halted_d  = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_class  = ALU_CLS_FUNCT;
                funct7_eff = funct7_5;
                state_d    = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_class  = ALU_CLS_FUNCT;
                // Bit 30 is part of the immediate except for SRAI/SRLI.
                funct7_eff = funct7_5 & (funct3 == 3'b101);
                state_d    = S_ALU_WB;
            end
            S_EXEC_LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALU_WB;
            end
            S_EXEC_AUIPC: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                register_write_en = 1'b1;
                result_src        = RES_ALU_OUT;
                retire            = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read_en = 1'b1;
                adr_src     = 1'b1;
                wait_d      = WAIT_INIT;
                state_d     = S_MRWAIT;
            end
            S_MRWAIT: begin
                if (wait_q == '0) begin
                    state_d = S_MEM_WB;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_MEM_WB: begin
                register_write_en = 1'b1;
                result_src        = RES_MEM_DATA;
                retire            = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEM_WRITE: begin
                memory_write_en = 1'b1;
                adr_src         = 1'b1;
                retire          = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                alu_class   = ALU_CLS_SUB;
                pc_write_en = branch_cond;
                pc_src      = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXEC_JALR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_d   = S_JUMP;
            end
            S_JUMP: begin
                // Link value old_pc+4 goes to rd while the target in alu_out loads PC.
                alu_src_a         = SRC_A_OLD_PC;
                alu_src_b         = SRC_B_FOUR;
                register_write_en = 1'b1;
                result_src        = RES_ALU_RESULT;
                pc_write_en       = 1'b1;
                pc_src            = 1'b1;
                retire            = 1'b1;
                state_d           = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                halted_d = 1'b1;
                state_d  = S_HALT;
            end
        endcase

        if (retire) begin
            instret_d = instret_q + CNT_WIDTH'(1);
        end

        // Reset is asynchronous, so the enables must drop the moment it rises,
        // not at the next clock edge.
        if (reset) begin
            pc_write_en       = 1'b0;
            old_pc_write_en   = 1'b0;
            ir_write_en       = 1'b0;
            register_write_en = 1'b0;
            memory_write_en   = 1'b0;
            mem_read_en       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
        end
    end

    assign instret = instret_q;
    assign illegal = illegal_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    localparam int LAT = 1;
    localparam int CW  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    funct3 = '0;
    logic          funct7_5 = 1'b0;
    logic          branch_cond = 1'b0;
    logic          pc_write_en, old_pc_write_en, ir_write_en, register_write_en;
    logic          memory_write_en, mem_read_en, adr_src, pc_src;
    logic [1:0]    alu_src_a, alu_src_b, result_src;
    logic [3:0]    alu_ctrl;
    logic          illegal, halted;
    logic [CW-1:0] instret;

    multicycle_control_fsm #(.MEM_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .opcode            (opcode),
        .funct3            (funct3),
        .funct7_5          (funct7_5),
        .branch_cond       (branch_cond),
        .pc_write_en       (pc_write_en),
        .old_pc_write_en   (old_pc_write_en),
        .ir_write_en       (ir_write_en),
        .register_write_en (register_write_en),
        .memory_write_en   (memory_write_en),
        .mem_read_en       (mem_read_en),
        .adr_src           (adr_src),
        .pc_src            (pc_src),
        .alu_src_a         (alu_src_a),
        .alu_src_b         (alu_src_b),
        .alu_ctrl          (alu_ctrl),
        .result_src        (result_src),
        .illegal           (illegal),
        .halted            (halted),
        .instret           (instret)
    );

    always #5 clk = ~clk;

    // One expected output vector per clock cycle.
    typedef struct {
        bit          pc_we, opc_we, ir_we, rf_we, mem_we, mem_re, adr, pcs;
        bit [1:0]    a, b, rs;
        bit [3:0]    ctrl;
        bit          halted, illegal, first;
        int unsigned cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned model_cnt = 0;
    bit          model_halted = 1'b0;
    bit          model_illegal = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e = '{default: 0};
        e.cnt     = model_cnt;
        e.halted  = model_halted;
        e.illegal = model_illegal;
        return e;
    endfunction

    // ALU operation from the RV32I funct3 table; alt = instruction[30] where it matters.
    function automatic bit [3:0] alu_of(input bit [2:0] f3, input bit alt);
        bit [3:0] base [8];
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (alt && f3 == 3'd0) return 4'd1;
        if (alt && f3 == 3'd5) return 4'd7;
        return base[f3];
    endfunction

    // Expand one instruction into its expected per-cycle output vectors.
    task automatic push_instr(input logic [31:0] w, input bit bc, input int halt_n);
        exp_t     e;
        bit [6:0] op;
        bit [2:0] f3;
        bit       f7;
        bit       retire;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[30];
        retire = 1'b1;

        e = blank(); e.first = 1; e.mem_re = 1; exp_q.push_back(e);
        for (int i = 0; i < LAT; i++) begin
            e = blank();
            if (i == LAT - 1) begin
                e.ir_we = 1; e.opc_we = 1; e.pc_we = 1; e.b = 2;
            end
            exp_q.push_back(e);
        end
        e = blank(); e.a = 1; e.b = 1; exp_q.push_back(e);

        case (op)
            7'h33, 7'h13, 7'h37, 7'h17: begin
                e = blank();
                case (op)
                    7'h33:   begin e.a = 2; e.b = 0; e.ctrl = alu_of(f3, f7); end
                    7'h13:   begin e.a = 2; e.b = 1; e.ctrl = alu_of(f3, f7 && f3 == 3'd5); end
                    7'h37:   begin e.a = 3; e.b = 1; end
                    default: begin e.a = 1; e.b = 1; end
                endcase
                exp_q.push_back(e);
                e = blank(); e.rf_we = 1; e.rs = 0; exp_q.push_back(e);
            end
            7'h03: begin
                e = blank(); e.a = 2; e.b = 1; exp_q.push_back(e);
                e = blank(); e.mem_re = 1; e.adr = 1; exp_q.push_back(e);
                for (int i = 0; i < LAT; i++) exp_q.push_back(blank());
                e = blank(); e.rf_we = 1; e.rs = 1; exp_q.push_back(e);
            end
            7'h23: begin
                e = blank(); e.a = 2; e.b = 1; exp_q.push_back(e);
                e = blank(); e.mem_we = 1; e.adr = 1; exp_q.push_back(e);
            end
            7'h63: begin
                e = blank(); e.a = 2; e.b = 0; e.ctrl = 1; e.pc_we = bc; e.pcs = 1;
                exp_q.push_back(e);
            end
            7'h67, 7'h6F: begin
                if (op == 7'h67) begin
                    e = blank(); e.a = 2; e.b = 1; exp_q.push_back(e);
                end
                e = blank(); e.a = 1; e.b = 2; e.rf_we = 1; e.rs = 2; e.pc_we = 1; e.pcs = 1;
                exp_q.push_back(e);
            end
            7'h0F: ;
            default: begin
                retire        = 1'b0;
                model_halted  = 1'b1;
                model_illegal = (op != 7'h73);
                for (int i = 0; i < halt_n; i++) exp_q.push_back(blank());
            end
        endcase
        if (retire) model_cnt++;
    endtask

    // Called at a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] w, input bit bc, input int halt_n);
        int n;
        opcode      = w[6:0];
        funct3      = w[14:12];
        funct7_5    = w[30];
        branch_cond = bc;
        push_instr(w, bc, halt_n);
        n = exp_q.size();
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_pc_write_en",       32'(pc_write_en),       32'd0);
        check("rst_old_pc_write_en",   32'(old_pc_write_en),   32'd0);
        check("rst_ir_write_en",       32'(ir_write_en),       32'd0);
        check("rst_register_write_en", 32'(register_write_en), 32'd0);
        check("rst_memory_write_en",   32'(memory_write_en),   32'd0);
        check("rst_mem_read_en",       32'(mem_read_en),       32'd0);
        check("rst_instret",           32'(instret),           32'd0);
        check("rst_halted",            32'(halted),            32'd0);
        check("rst_illegal",           32'(illegal),           32'd0);
        exp_q.delete();
        model_cnt     = 0;
        model_halted  = 1'b0;
        model_illegal = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Per-cycle compare against the model, plus a log of when key events happened.
    exp_t       cur;
    int         cyc = 0;
    int         rf_cyc = 0;
    int         mw_cyc = 0;
    logic [1:0] rf_src = '0;
    logic       mw_adr = 1'b0;
    logic [15:0] mr_mask = '0;
    logic       pc4_we = 1'b0;
    logic       pc4_src = 1'b0;
    logic [3:0] ctrl4 = '0;

    always begin
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            if (cur.first) begin
                cyc = 0; rf_cyc = 0; mw_cyc = 0; rf_src = '0; mw_adr = 1'b0;
                mr_mask = '0; pc4_we = 1'b0; pc4_src = 1'b0; ctrl4 = '0;
            end
            cyc++;
            check("pc_write_en",       32'(pc_write_en),       32'(cur.pc_we));
            check("old_pc_write_en",   32'(old_pc_write_en),   32'(cur.opc_we));
            check("ir_write_en",       32'(ir_write_en),       32'(cur.ir_we));
            check("register_write_en", 32'(register_write_en), 32'(cur.rf_we));
            check("memory_write_en",   32'(memory_write_en),   32'(cur.mem_we));
            check("mem_read_en",       32'(mem_read_en),       32'(cur.mem_re));
            check("adr_src",           32'(adr_src),           32'(cur.adr));
            check("pc_src",            32'(pc_src),            32'(cur.pcs));
            check("alu_src_a",         32'(alu_src_a),         32'(cur.a));
            check("alu_src_b",         32'(alu_src_b),         32'(cur.b));
            check("alu_ctrl",          32'(alu_ctrl),          32'(cur.ctrl));
            check("result_src",        32'(result_src),        32'(cur.rs));
            check("halted",            32'(halted),            32'(cur.halted));
            check("illegal",           32'(illegal),           32'(cur.illegal));
            check("instret",           32'(instret),           cur.cnt);
            if (register_write_en) begin rf_cyc = cyc; rf_src = result_src; end
            if (memory_write_en)   begin mw_cyc = cyc; mw_adr = adr_src;    end
            if (mem_read_en && cyc < 16) mr_mask[cyc] = 1'b1;
            if (cyc == 4) begin pc4_we = pc_write_en; pc4_src = pc_src; ctrl4 = alu_ctrl; end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete by t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    logic [31:0] others [12];

    initial begin
        others = '{32'h0020C1B3, 32'h0020B1B3, 32'h0020F1B3, 32'h0020E1B3,
                   32'h002091B3, 32'h0020A1B3, 32'h0020D1B3, 32'h123451B7,
                   32'h00001197, 32'h008000EF, 32'h000080E7, 32'h0000000F};
        #1;
        do_reset();

        run_instr(32'h002081B3, 1'b0, 0);          // ADD x3,x1,x2
        check("add_wb_cycle",   32'(rf_cyc), 32'd5);
        check("add_wb_src",     32'(rf_src), 32'd0);
        check("add_instret",    instret,     32'd1);

        run_instr(32'h0000A183, 1'b0, 0);          // LW
        check("lw_read_cycles", 32'(mr_mask), 32'h22);
        check("lw_wb_cycle",    32'(rf_cyc),  32'd7);
        check("lw_wb_src",      32'(rf_src),  32'd1);

        run_instr(32'h0030A223, 1'b0, 0);          // SW
        check("sw_write_cycle", 32'(mw_cyc), 32'd5);
        check("sw_adr_src",     32'(mw_adr), 32'd1);

        run_instr(32'h00208463, 1'b1, 0);          // BEQ taken
        check("beq_t_pc_we",    32'(pc4_we),  32'd1);
        check("beq_t_pc_src",   32'(pc4_src), 32'd1);
        run_instr(32'h00208463, 1'b0, 0);          // BEQ not taken
        check("beq_nt_pc_we",   32'(pc4_we),  32'd0);

        run_instr(32'h402081B3, 1'b0, 0);          // SUB
        check("sub_alu_ctrl",   32'(ctrl4), 32'd1);
        run_instr(32'h4020D1B3, 1'b0, 0);          // SRA
        check("sra_alu_ctrl",   32'(ctrl4), 32'd7);
        run_instr(32'h4030D193, 1'b0, 0);          // SRAI
        check("srai_alu_ctrl",  32'(ctrl4), 32'd7);
        run_instr(32'h40008193, 1'b0, 0);          // ADDI with bit 30 set
        check("addi_alu_ctrl",  32'(ctrl4), 32'd0);

        foreach (others[i]) run_instr(others[i], 1'b0, 0);
        check("instret_21",     instret, 32'd21);

        run_instr(32'h00000073, 1'b0, 20);         // ECALL -> HALT, not illegal
        check("ecall_halted",   32'(halted),  32'd1);
        check("ecall_illegal",  32'(illegal), 32'd0);
        check("ecall_instret",  instret,      32'd21);
        do_reset();

        // Abandon an ADD while it sits in EXEC_R.
        opcode = 7'h33; funct3 = 3'd0; funct7_5 = 1'b0; branch_cond = 1'b0;
        push_instr(32'h002081B3, 1'b0, 0);
        repeat (3) @(negedge clk);
        #3;
        do_reset();

        run_instr(32'h002081B3, 1'b0, 0);
        check("post_rst_instret", instret, 32'd1);

        run_instr(32'h0000007F, 1'b0, 100);        // unknown opcode
        check("ill_illegal",    32'(illegal), 32'd1);
        check("ill_halted",     32'(halted),  32'd1);
        check("ill_instret",    instret,      32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
